// File: rtl/if_id_fifo.sv
// IF->ID stage buffer: a DEPTH-entry valid/ready queue between fetch and decode.
// An empty queue presents NOP_INS/RESET_ADDR, so decode never sees a stale instruction.
module if_id_fifo #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DEPTH      = 2,
    parameter logic [DATA_W-1:0] NOP_INS    = 32'h00000013,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        ins_i,
    input  logic [ADDR_W-1:0]        ins_addr_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        ins_o,
    output logic [ADDR_W-1:0]        ins_addr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] insMem_q  [DEPTH];
    logic [ADDR_W-1:0] addrMem_q [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Handshake flags depend only on registered occupancy, never on out_ready_i,
    // so a full queue refuses a push even when decode drains in the same cycle.
    assign in_ready_o  = (count_q != FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign count_o     = count_q;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    assign ins_o      = out_valid_o ? insMem_q[rdPtr_q]  : NOP_INS;
    assign ins_addr_o = out_valid_o ? addrMem_q[rdPtr_q] : RESET_ADDR;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; entries are only observable while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            insMem_q[wrPtr_q]  <= ins_i;
            addrMem_q[wrPtr_q] <= ins_addr_i;
        end
    end

endmodule

// File: tb/tb_if_id_fifo.sv
// Self-checking bench for if_id_fifo: scenario tasks plus a queue scoreboard
// that tracks pushes/pops on a DEPTH=2 and a DEPTH=4 instance.
module tb_if_id_fifo;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;

    logic        aFlush, aInValid, aInReady, aOutValid, aOutReady;
    logic [31:0] aIns, aAddr, aInsO, aAddrO;
    logic [1:0]  aCount;

    logic        bFlush, bInValid, bInReady, bOutValid, bOutReady;
    logic [31:0] bIns, bAddr, bInsO, bAddrO;
    logic [2:0]  bCount;

    int checkCount = 0;
    int passCount  = 0;
    int bRecv      = 0;

    logic [63:0] expA[$];
    logic [63:0] expB[$];

    always #5 clk = ~clk;

    if_id_fifo #(.DEPTH(2)) dutA (
        .clk(clk), .rst(rst), .flush_i(aFlush),
        .in_valid_i(aInValid), .in_ready_o(aInReady),
        .ins_i(aIns), .ins_addr_i(aAddr),
        .out_valid_o(aOutValid), .out_ready_i(aOutReady),
        .ins_o(aInsO), .ins_addr_o(aAddrO), .count_o(aCount)
    );

    if_id_fifo #(.DEPTH(4)) dutB (
        .clk(clk), .rst(rst), .flush_i(bFlush),
        .in_valid_i(bInValid), .in_ready_o(bInReady),
        .ins_i(bIns), .ins_addr_i(bAddr),
        .out_valid_o(bOutValid), .out_ready_i(bOutReady),
        .ins_o(bInsO), .ins_addr_o(bAddrO), .count_o(bCount)
    );

    // Scoreboard: inputs are stable from posedge+1, so at each negedge the
    // handshakes that the next edge will perform are already known.
    always @(negedge clk) begin
        checkCount++;
        if (aCount !== 2'(expA.size()) || aOutValid !== (expA.size() != 0) || aInReady !== (expA.size() != 2))
            $display("[TB] FAIL sbA_state: count=%0d valid=%b ready=%b, expected count=%0d", aCount, aOutValid, aInReady, expA.size());
        else passCount++;
        if (expA.size() == 0) begin
            checkCount++;
            if (aInsO !== NOP || aAddrO !== 32'd0)
                $display("[TB] FAIL sbA_empty_out: ins=%h addr=%h, expected ins=%h addr=0", aInsO, aAddrO, NOP);
            else passCount++;
        end
        if (rst || aFlush) expA.delete();
        else begin
            if (aOutValid && aOutReady) begin
                checkCount++;
                if (expA.size() == 0 || {aInsO, aAddrO} !== expA[0])
                    $display("[TB] FAIL sbA_pop: got %h/%h, expected %h", aInsO, aAddrO, (expA.size() != 0) ? expA[0] : 64'd0);
                else passCount++;
                if (expA.size() != 0) void'(expA.pop_front());
            end
            if (aInValid && aInReady) expA.push_back({aIns, aAddr});
        end

        checkCount++;
        if (bCount !== 3'(expB.size()) || bOutValid !== (expB.size() != 0) || bInReady !== (expB.size() != 4))
            $display("[TB] FAIL sbB_state: count=%0d valid=%b ready=%b, expected count=%0d", bCount, bOutValid, bInReady, expB.size());
        else passCount++;
        if (rst || bFlush) expB.delete();
        else begin
            if (bOutValid && bOutReady) begin
                checkCount++;
                if (expB.size() == 0 || {bInsO, bAddrO} !== expB[0])
                    $display("[TB] FAIL sbB_pop: got %h/%h, expected %h", bInsO, bAddrO, (expB.size() != 0) ? expB[0] : 64'd0);
                else passCount++;
                if (expB.size() != 0) void'(expB.pop_front());
                bRecv++;
            end
            if (bInValid && bInReady) expB.push_back({bIns, bAddr});
        end
    end

    task automatic setA(input logic v, input logic [31:0] ins, input logic [31:0] addr,
                        input logic ordy, input logic fl);
        @(posedge clk); #1;
        aInValid = v; aIns = ins; aAddr = addr; aOutReady = ordy; aFlush = fl;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                @(posedge clk); #1;
                rst = 1'b0; aInValid = 1'b0;
            end
            @(negedge clk);
            checkCount++;
            if ({aOutValid, aInReady, aCount, aInsO, aAddrO} !== {1'b0, 1'b1, 2'd0, NOP, 32'd0})
                $display("[TB] FAIL reset_%0d: valid=%b ready=%b count=%0d ins=%h addr=%h, expected 0/1/0/%h/0",
                         i, aOutValid, aInReady, aCount, aInsO, aAddrO, NOP);
            else passCount++;
        end
    endtask

    task automatic test_streaming();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 4; i++) begin
            setA(i < 3, 32'h00100093 + 32'(i << 20), (i < 3) ? addrs[i] : 32'h0, 1'b1, 1'b0);
            @(negedge clk);
            if (i == 0) begin
                checkCount++;
                if (aInsO !== NOP) $display("[TB] FAIL stream_no_bypass: ins=%h, expected %h", aInsO, NOP);
                else passCount++;
            end else begin
                checkCount++;
                if (aCount !== 2'd1 || aAddrO !== addrs[i-1])
                    $display("[TB] FAIL stream_%0d: count=%0d addr=%h, expected count=1 addr=%h", i, aCount, aAddrO, addrs[i-1]);
                else passCount++;
            end
        end
        setA(0, 0, 0, 0, 0);
        @(negedge clk);
        checkCount++;
        if (aCount !== 2'd0) $display("[TB] FAIL stream_drain: count=%0d, expected 0", aCount);
        else passCount++;
    endtask

    task automatic test_stall_fill();
        setA(1, 32'h11, 32'h10, 0, 0);
        setA(1, 32'h15, 32'h14, 0, 0);
        setA(1, 32'h19, 32'h18, 0, 0);
        @(negedge clk);
        checkCount++;
        if (aCount !== 2'd2 || aInReady !== 1'b0 || aAddrO !== 32'h10)
            $display("[TB] FAIL stall_full: count=%0d ready=%b addr=%h, expected 2/0/10", aCount, aInReady, aAddrO);
        else passCount++;
        setA(1, 32'h19, 32'h18, 0, 0);
        @(negedge clk);
        checkCount++;
        if (aInsO !== 32'h11 || aAddrO !== 32'h10)
            $display("[TB] FAIL stall_hold: ins=%h addr=%h, expected 11/10", aInsO, aAddrO);
        else passCount++;
        setA(1, 32'h19, 32'h18, 1, 0);
        setA(1, 32'h19, 32'h18, 1, 0);
        @(negedge clk);
        checkCount++;
        if (aCount !== 2'd1 || aAddrO !== 32'h14)
            $display("[TB] FAIL stall_release: count=%0d addr=%h, expected 1/14", aCount, aAddrO);
        else passCount++;
        setA(0, 0, 0, 1, 0);
        @(negedge clk);
        checkCount++;
        if (aAddrO !== 32'h18) $display("[TB] FAIL stall_last: addr=%h, expected 18", aAddrO);
        else passCount++;
        setA(0, 0, 0, 0, 0);
    endtask

    task automatic test_full_pop();
        setA(1, 32'h31, 32'h30, 0, 0);
        setA(1, 32'h35, 32'h34, 0, 0);
        setA(1, 32'h39, 32'h38, 1, 0);
        setA(1, 32'h39, 32'h38, 1, 0);
        @(negedge clk);
        checkCount++;
        if (aCount !== 2'd1 || aAddrO !== 32'h34)
            $display("[TB] FAIL full_pop_refuse: count=%0d addr=%h, expected 1/34", aCount, aAddrO);
        else passCount++;
        setA(0, 0, 0, 1, 0);
        @(negedge clk);
        checkCount++;
        if (aCount !== 2'd1 || aAddrO !== 32'h38)
            $display("[TB] FAIL full_pop_retry: count=%0d addr=%h, expected 1/38", aCount, aAddrO);
        else passCount++;
        setA(0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        setA(1, 32'h21, 32'h20, 0, 0);
        setA(1, 32'h25, 32'h24, 0, 0);
        setA(1, 32'h41, 32'h40, 1, 1);
        setA(1, 32'h81, 32'h80, 0, 0);
        @(negedge clk);
        checkCount++;
        if ({aCount, aOutValid, aInReady, aInsO} !== {2'd0, 1'b0, 1'b1, NOP})
            $display("[TB] FAIL flush_full: count=%0d valid=%b ready=%b ins=%h, expected 0/0/1/%h", aCount, aOutValid, aInReady, aInsO, NOP);
        else passCount++;
        setA(0, 0, 0, 0, 0);
        @(negedge clk);
        checkCount++;
        if (aOutValid !== 1'b1 || aAddrO !== 32'h80)
            $display("[TB] FAIL flush_next_push: valid=%b addr=%h, expected 1/80", aOutValid, aAddrO);
        else passCount++;
        setA(0, 0, 0, 1, 0);
        setA(0, 0, 0, 0, 1);
        setA(0, 0, 0, 0, 0);
        @(negedge clk);
        checkCount++;
        if (aCount !== 2'd0 || aOutValid !== 1'b0)
            $display("[TB] FAIL flush_empty: count=%0d valid=%b, expected 0/0", aCount, aOutValid);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        setA(1, 32'h51, 32'h50, 0, 0);
        setA(1, 32'h55, 32'h54, 1, 0);
        setA(1, 32'h59, 32'h58, 1, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        aInValid = 1'b0; aOutReady = 1'b0; aFlush = 1'b0;
        @(negedge clk);
        checkCount++;
        if ({aOutValid, aInReady, aCount, aInsO, aAddrO} !== {1'b0, 1'b1, 2'd0, NOP, 32'd0})
            $display("[TB] FAIL reset_mid: valid=%b ready=%b count=%0d ins=%h addr=%h, expected 0/1/0/%h/0",
                     aOutValid, aInReady, aCount, aInsO, aAddrO, NOP);
        else passCount++;
    endtask

    task automatic test_wrap_around();
        int sent   = 0;
        int cycles = 0;
        bRecv = 0;
        while (bRecv < 11 && cycles < 400) begin
            @(posedge clk); #1;
            bOutReady = 1'($urandom_range(0, 1));
            bInValid  = (sent < 11);
            bIns      = 32'hA000_0000 + 32'(sent);
            bAddr     = 32'h200 + 32'(sent * 4);
            if (bInValid && bInReady) sent++;
            @(negedge clk);
            checkCount++;
            if ((bCount <= 3'd4) !== 1'b1) $display("[TB] FAIL wrap_count_bound: count=%0d, expected <=4", bCount);
            else passCount++;
            cycles++;
        end
        @(posedge clk); #1;
        bInValid = 1'b0; bOutReady = 1'b0;
        checkCount++;
        if (bRecv != 11) $display("[TB] FAIL wrap_received: got %0d entries, expected 11", bRecv);
        else passCount++;
    endtask

    initial begin
        rst = 1'b1;
        aFlush = 1'b0; aInValid = 1'b1; aIns = 32'h00100093; aAddr = 32'h100; aOutReady = 1'b1;
        bFlush = 1'b0; bInValid = 1'b0; bIns = '0; bAddr = '0; bOutReady = 1'b0;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_full_pop();
        test_flush();
        test_reset_mid();
        test_wrap_around();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
